alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational 16-bit ALU between two requesters (req0, req1) using round-robin arbitration and valid/ready handshakes. The block registers the granted operands and opcode, sequences execution, and stalls for multiply. It returns the registered result, flags and requester id on one response channel. It sits between the instruction-issue logic and the ALU datapath.

Parameters:
WIDTH, 16, operand width; fixed at 16 for the current ALU, present for package consistency
MUL_CYCLES, 2, extra stall cycles inserted before capturing a multiply result (0 allowed)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  16  operand A
req0_b  in  16  operand B
req0_sel  in  4  ALU opcode
req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as req0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that issued the result
rsp_hi  out  16  upper product half (0 for non-MUL)
rsp_lo  out  16  result / lower product half
rsp_c  out  1  carry flag (ADD carry, SUB borrow, SHL shifted-out bit)
rsp_z  out  1  zero flag (rsp_lo == 0)
rsp_err  out  1  illegal opcode
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rsp_valid=0; rsp_id, rsp_hi, rsp_lo, rsp_c, rsp_z, rsp_err, busy all 0; operand/opcode registers=0; last_grant=1, so req0 wins first. An in-flight operation is discarded with no response.
- Legal opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 SHL, 5 OR, 6 XOR, 7 NOT, 8 AND, 9 OR.
  - 4 and A..F are illegal and are never forwarded to the ALU.
- The ALU inputs are driven only from the internal operand/opcode registers, never directly from the request ports.
- FSM states: IDLE, WAIT_MUL, EXEC, HOLD.
- IDLE:
  - If either valid is high, grant one: the only valid requester, or if both are valid, the one that is not last_grant.
  - The granted reqN_ready is high combinationally in the same cycle. The other ready stays 0.
  - On the edge: capture a, b, sel and id; last_grant becomes the id.
  - Next state is WAIT_MUL if sel==2 and MUL_CYCLES>0, else EXEC.
  - Ready is 0 in every state other than IDLE.
- WAIT_MUL: a down-counter loaded with MUL_CYCLES-1 on entry. Move to EXEC when the count is 0.
- EXEC (one cycle): latch the ALU Out_1/Out_0/cFlag/zFlag into rsp_hi/rsp_lo/rsp_c/rsp_z. Set rsp_valid=1. Go to HOLD.
  - For an illegal opcode: hi=0, lo=0, c=0, z=0, err=1.
  - For a legal opcode: err=0.
- HOLD:
  - All rsp_* outputs are stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid drops to 0 and state goes to IDLE. The data outputs keep their values.
  - No new request is accepted in the HOLD cycle, so back-to-back operations have a one-cycle bubble.
- Latency, with acceptance at edge T:
  - Non-MUL or illegal: rsp_valid high from cycle T+2.
  - MUL: rsp_valid high from cycle T+2+MUL_CYCLES.
  - Throughput: at most one operation per 3 cycles (non-MUL, rsp_ready tied high).
- Requesters hold a/b/sel stable while valid && !ready. Dropping valid before ready is allowed, and nothing is captured.
- last_grant changes only on an actual grant.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_OR2).
  - State encoding for IDLE/WAIT_MUL/EXEC/HOLD.
  - is_legal_op(sel) function.
  - WIDTH constant.
- Sub-module: the existing ALU module, instantiated once as the datapath. All sequencing, arbitration and the counter live in alu_arbiter.

Test Plan:
- Reset, then req0 ADD a=FFFF b=0001 accepted at T -> rsp_valid at T+2: id=0, lo=0000, hi=0000, c=1, z=1, err=0.
- req1 SUB a=0003 b=0005 -> lo=FFFE, c=1, z=0, id=1. SUB a=0005 b=0003 -> lo=0002, c=0.
- req0 MUL a=0100 b=0100, MUL_CYCLES=2 -> rsp_valid at T+4: hi=0001, lo=0000, z=1. During the wait, busy=1 and both readys are 0.
- Both requesters valid continuously from reset with rsp_ready=1 -> grants alternate 0,1,0,1, one accept every 3 cycles.
- Second test on backpressure and an illegal opcode:
  - rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields unchanged, readys 0, then one cycle after rsp_ready=1 the next grant occurs.
  - sel=C -> err=1, lo=0, z=0.
- rst_n pulsed low during WAIT_MUL -> rsp_valid=0 immediately, no stale response. After release, with both valid, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM encoding, request record.
package alu_pkg;

   localparam int WIDTH = 16;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_SHL = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_AND = 4'h8;
   localparam logic [3:0] OP_OR2 = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MUL = 2'd1,
      ST_EXEC     = 2'd2,
      ST_HOLD     = 2'd3
   } state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [3:0]       sel;
   } alu_req_t;

   // Opcode 4 and A..F have no ALU function behind them.
   function automatic logic is_legal_op(input logic [3:0] sel);
      case (sel)
         OP_ADD, OP_SUB, OP_MUL, OP_SHL, OP_OR,
         OP_XOR, OP_NOT, OP_AND, OP_OR2: is_legal_op = 1'b1;
         default:                        is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit ALU datapath. SHL shifts A left by one; cFlag is the bit shifted out.
module alu_core
   import alu_pkg::*;
(
   input  logic [3:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] Out_1,
   output logic [WIDTH-1:0] Out_0,
   output logic             cFlag,
   output logic             zFlag
);

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   // Operation decode; SUB carry is the borrow out of the 17-bit difference.
   always_comb begin
      sum   = '0;
      prod  = '0;
      Out_1 = '0;
      Out_0 = '0;
      cFlag = 1'b0;
      case (sel)
         OP_ADD: begin
            sum   = {1'b0, a} + {1'b0, b};
            Out_0 = sum[WIDTH-1:0];
            cFlag = sum[WIDTH];
         end
         OP_SUB: begin
            sum   = {1'b0, a} - {1'b0, b};
            Out_0 = sum[WIDTH-1:0];
            cFlag = sum[WIDTH];
         end
         OP_MUL: begin
            prod  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
            Out_1 = prod[2*WIDTH-1:WIDTH];
            Out_0 = prod[WIDTH-1:0];
         end
         OP_SHL: begin
            Out_0 = {a[WIDTH-2:0], 1'b0};
            cFlag = a[WIDTH-1];
         end
         OP_OR, OP_OR2: Out_0 = a | b;
         OP_XOR:        Out_0 = a ^ b;
         OP_NOT:        Out_0 = ~a;
         OP_AND:        Out_0 = a & b;
         default:       Out_0 = '0;
      endcase
   end

   assign zFlag = (Out_0 == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two requesters, with a
// registered single-entry response channel and a multiply stall counter.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH      = alu_pkg::WIDTH,
   parameter int MUL_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_hi,
   output logic [WIDTH-1:0] rsp_lo,
   output logic             rsp_c,
   output logic             rsp_z,
   output logic             rsp_err,
   output logic             busy
);

   localparam int                CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = (MUL_CYCLES > 0) ? CNT_W'(MUL_CYCLES - 1) : '0;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   alu_req_t         op_q, op_d;
   logic             id_q, id_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
   logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
   logic             rsp_c_q, rsp_c_d;
   logic             rsp_z_q, rsp_z_d;
   logic             rsp_err_q, rsp_err_d;

   logic             gnt_vld;
   logic             gnt_id;
   alu_req_t         gnt_req;
   logic [WIDTH-1:0] alu_hi, alu_lo;
   logic             alu_c, alu_z;

   // Grant only in IDLE; on contention the requester that did not win last time goes.
   always_comb begin
      gnt_vld = (state_q == ST_IDLE) && (req0_valid || req1_valid);
      gnt_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      gnt_req = gnt_id ? '{a: req1_a, b: req1_b, sel: req1_sel}
                       : '{a: req0_a, b: req0_b, sel: req0_sel};
   end

   assign req0_ready = gnt_vld & ~gnt_id;
   assign req1_ready = gnt_vld &  gnt_id;

   // ALU sees only the captured operands, so request ports may change freely after acceptance.
   alu_core u_alu (
      .sel   (op_q.sel),
      .a     (op_q.a),
      .b     (op_q.b),
      .Out_1 (alu_hi),
      .Out_0 (alu_lo),
      .cFlag (alu_c),
      .zFlag (alu_z)
   );

   // Sequencing: capture -> optional multiply stall -> latch result -> hold until taken.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      id_d         = id_q;
      ill_d        = ill_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_hi_d     = rsp_hi_q;
      rsp_lo_d     = rsp_lo_q;
      rsp_c_d      = rsp_c_q;
      rsp_z_d      = rsp_z_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               id_d         = gnt_id;
               last_grant_d = gnt_id;
               ill_d        = !is_legal_op(gnt_req.sel);
               op_d         = gnt_req;
               // Illegal opcodes are parked as ADD so the ALU never decodes them.
               if (ill_d) op_d.sel = OP_ADD;
               if (gnt_req.sel == OP_MUL && MUL_CYCLES > 0) begin
                  state_d = ST_WAIT_MUL;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_WAIT_MUL: begin
            if (cnt_q == '0) state_d = ST_EXEC;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_EXEC: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_err_d   = ill_q;
            rsp_hi_d    = ill_q ? '0   : alu_hi;
            rsp_lo_d    = ill_q ? '0   : alu_lo;
            rsp_c_d     = ill_q ? 1'b0 : alu_c;
            rsp_z_d     = ill_q ? 1'b0 : alu_z;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= '0;
         id_q         <= 1'b0;
         ill_q        <= 1'b0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_hi_q     <= '0;
         rsp_lo_q     <= '0;
         rsp_c_q      <= 1'b0;
         rsp_z_q      <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         id_q         <= id_d;
         ill_q        <= ill_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_hi_q     <= rsp_hi_d;
         rsp_lo_q     <= rsp_lo_d;
         rsp_c_q      <= rsp_c_d;
         rsp_z_q      <= rsp_z_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_hi    = rsp_hi_q;
   assign rsp_lo    = rsp_lo_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: handshakes, latency, flags, arbitration, backpressure, reset.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [15:0] req0_a, req0_b;
   logic [3:0]  req0_sel;
   logic        req1_valid, req1_ready;
   logic [15:0] req1_a, req1_b;
   logic [3:0]  req1_sel;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_hi, rsp_lo;
   logic        rsp_c, rsp_z, rsp_err, busy;

   int n_tests = 0;
   int n_fail  = 0;

   alu_arbiter #(.WIDTH(16), .MUL_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sel   (req0_sel),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sel   (req1_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_hi     (rsp_hi),
      .rsp_lo     (rsp_lo),
      .rsp_c      (rsp_c),
      .rsp_z      (rsp_z),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one request, wait for its grant, then count negedges until rsp_valid.
   // wait_ok clears if busy drops or any ready rises while the result is pending.
   task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sel, output int lat, output logic wait_ok);
      int cyc;
      if (id) begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
      else    begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
      #1;
      cyc = 0;
      while (!(id ? req1_ready : req0_ready) && cyc < 20) begin
         @(posedge clk); #1; cyc++;
      end
      chk("grant_seen", id ? req1_ready : req0_ready, 1);
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
      lat = 0;
      wait_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (!rsp_valid && (!busy || req0_ready || req1_ready)) wait_ok = 1'b0;
      end while (!rsp_valid && lat < 20);
   endtask

   initial begin
      int   lat;
      logic wok;
      int   g_id[$];
      int   g_cyc[$];
      logic ok;

      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
      repeat (2) @(negedge clk);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_lo",    rsp_lo, 0);
      chk("rst_flags", {rsp_id, rsp_c, rsp_z, rsp_err, rsp_hi}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // ADD FFFF+0001 wraps to zero with carry out
      run_op(0, 16'hFFFF, 16'h0001, 4'h0, lat, wok);
      chk("add_lat", lat, 2);
      chk("add_id",  rsp_id, 0);
      chk("add_lo",  rsp_lo, 16'h0000);
      chk("add_hi",  rsp_hi, 16'h0000);
      chk("add_c",   rsp_c, 1);
      chk("add_z",   rsp_z, 1);
      chk("add_err", rsp_err, 0);

      // SUB with and without borrow
      run_op(1, 16'h0003, 16'h0005, 4'h1, lat, wok);
      chk("sub1_lo", rsp_lo, 16'hFFFE);
      chk("sub1_c",  rsp_c, 1);
      chk("sub1_z",  rsp_z, 0);
      chk("sub1_id", rsp_id, 1);
      run_op(1, 16'h0005, 16'h0003, 4'h1, lat, wok);
      chk("sub2_lo", rsp_lo, 16'h0002);
      chk("sub2_c",  rsp_c, 0);

      // MUL stalls; req1 waits alongside and must not see ready
      req1_a = 16'h1111; req1_b = 16'h2222; req1_sel = 4'h0; req1_valid = 1'b1;
      run_op(0, 16'h0100, 16'h0100, 4'h2, lat, wok);
      req1_valid = 1'b0;
      chk("mul_lat",  lat, 4);
      chk("mul_wait", wok, 1);
      chk("mul_id",   rsp_id, 0);
      chk("mul_hi",   rsp_hi, 16'h0001);
      chk("mul_lo",   rsp_lo, 16'h0000);
      chk("mul_z",    rsp_z, 1);

      // Both valid from reset: grants alternate 0,1,0,1 every 3 cycles
      rst_n = 1'b0;
      req0_a = 16'h0001; req0_b = 16'h0001; req0_sel = 4'h0; req0_valid = 1'b1;
      req1_a = 16'h0002; req1_b = 16'h0002; req1_sel = 4'h6; req1_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req0_ready) begin g_id.push_back(0); g_cyc.push_back(c); end
         if (req1_ready) begin g_id.push_back(1); g_cyc.push_back(c); end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_count", g_id.size(), 4);
      if (g_id.size() >= 4) begin
         chk("rr_order", {g_id[0][7:0], g_id[1][7:0], g_id[2][7:0], g_id[3][7:0]}, 32'h00010001);
         chk("rr_first", g_cyc[0], 0);
         chk("rr_gap",   {g_cyc[1][7:0] - g_cyc[0][7:0], g_cyc[2][7:0] - g_cyc[1][7:0],
                          g_cyc[3][7:0] - g_cyc[2][7:0]}, 24'h030303);
      end
      for (int c = 0; c < 10 && busy; c++) @(negedge clk);
      chk("rr_drain", busy, 0);

      // Backpressure: response frozen, no grants, then grant one cycle after release
      rsp_ready = 1'b0;
      run_op(1, 16'h0007, 16'h0008, 4'h0, lat, wok);
      chk("bp_lat", lat, 2);
      req0_a = 16'h1234; req0_b = 16'h5678; req0_sel = 4'hC; req0_valid = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_lo !== 16'h000F || rsp_id !== 1'b1 || rsp_c || rsp_z ||
             rsp_err || req0_ready || req1_ready) ok = 1'b0;
      end
      chk("bp_stable", ok, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_drop",   rsp_valid, 0);
      chk("bp_keep",   rsp_lo, 16'h000F);
      chk("bp_regrant", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("ill_pend", rsp_valid, 0);
      @(negedge clk);
      chk("ill_valid", rsp_valid, 1);
      chk("ill_err",   rsp_err, 1);
      chk("ill_lo",    rsp_lo, 0);
      chk("ill_z",     rsp_z, 0);
      chk("ill_hic",   {rsp_hi, rsp_c}, 0);
      chk("ill_id",    rsp_id, 0);
      @(negedge clk);

      // Reset during the multiply stall discards it
      req0_a = 16'h0003; req0_b = 16'h0004; req0_sel = 4'h2; req0_valid = 1'b1;
      #1;
      chk("rm_grant", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("rm_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rm_valid", rsp_valid, 0);
      chk("rm_idle",  busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (rsp_valid || busy) ok = 1'b0;
      end
      chk("rm_nostale", ok, 1);
      req0_a = 16'h0001; req0_sel = 4'h0; req0_valid = 1'b1;
      req1_a = 16'h0001; req1_sel = 4'h0; req1_valid = 1'b1;
      #1;
      chk("rm_first", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case a wait above is not bounded as intended.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
